traffic_gen: RTL and testbench

TRAFFIC_GEN -- requirements
Module: traffic_gen

---
 rtl/traffic_gen.sv | 101 ++++++++++
 tb/tb_traffic_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_gen.sv
// traffic_gen: patterned burst pusher into a main FIFO that drains destination FIFOs and flags mismatches or timeouts
module traffic_gen #(
  parameter int DATA_SIZE = 6,
  parameter int NUM_DEST = 2,
  parameter int LEN_SIZE = 8,
  parameter int INIT_CYCLES = 2,
  parameter int QUIET_CYCLES = 4,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_SIZE-1:0] LFSR_TAPS = 6'b110000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [DATA_SIZE-1:0] seed,
  input  logic [LEN_SIZE-1:0]  burst_len,
  input  logic                 fifo_pause_main,
  input  logic [NUM_DEST-1:0]  fifo_empty_d,
  output logic                 push_main,
  output logic [DATA_SIZE-1:0] data_in,
  output logic [NUM_DEST-1:0]  pop_d,
  output logic                 init,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [LEN_SIZE-1:0]  push_count,
  output logic [LEN_SIZE-1:0]  pop_count
);
  typedef enum logic [2:0] {IDLE, INIT, PUSH, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [1:0] mode_r;
  logic [LEN_SIZE-1:0] len_r, init_cnt, quiet_cnt, drain_cnt, npop;
  logic [LEN_SIZE:0] pop_sum;
  logic [DATA_SIZE-1:0] data_nx;
  logic accept, init_end, last_push, quiet_end, time_end, all_empty;
  assign push_main = state == PUSH && !fifo_pause_main;
  assign pop_d = (state == PUSH || state == DRAIN) ? ~fifo_empty_d : '0;
  assign init = state == INIT;
  assign busy = state == INIT || state == PUSH || state == DRAIN;
  assign done = state == DONE;
  assign all_empty = &fifo_empty_d;
  assign accept = start && (state == IDLE || state == DONE);
  assign init_end = init_cnt == LEN_SIZE'(INIT_CYCLES - 1);
  assign last_push = push_main && (push_count + LEN_SIZE'(1)) == len_r;
  assign quiet_end = all_empty && quiet_cnt == LEN_SIZE'(QUIET_CYCLES - 1);
  assign time_end = drain_cnt == LEN_SIZE'(TIMEOUT - 1);
  assign pop_sum = {1'b0, pop_count} + {1'b0, npop};
  assign data_nx = mode_r == 2'd0 ? data_in + DATA_SIZE'(1) :
                   mode_r == 2'd1 ? data_in - DATA_SIZE'(1) :
                   mode_r == 2'd2 ? data_in :
                   {data_in[DATA_SIZE-2:0], ^(data_in & LFSR_TAPS)};
  always_comb begin
    npop = '0;
    for (int i = 0; i < NUM_DEST; i++) npop = npop + LEN_SIZE'(pop_d[i]);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? INIT : state;
      INIT:       state_n = !init_end ? INIT : len_r == '0 ? DRAIN : PUSH;
      PUSH:       state_n = last_push ? DRAIN : PUSH;
      DRAIN:      state_n = quiet_end || time_end ? DONE : DRAIN;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      data_in <= '0;
      mode_r <= '0;
      len_r <= '0;
      push_count <= '0;
      pop_count <= '0;
      error <= 1'b0;
      init_cnt <= '0;
      quiet_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      init_cnt <= state == INIT ? init_cnt + LEN_SIZE'(1) : '0;
      quiet_cnt <= state == DRAIN && all_empty ? quiet_cnt + LEN_SIZE'(1) : '0;
      drain_cnt <= state == DRAIN ? drain_cnt + LEN_SIZE'(1) : '0;
      if (accept) begin
        // an all-zero LFSR would lock up, so mode 3 starts from 1 instead
        data_in <= (mode == 2'd3 && seed == '0) ? DATA_SIZE'(1) : seed;
        mode_r <= mode;
        len_r <= burst_len;
        push_count <= '0;
        pop_count <= '0;
        error <= 1'b0;
      end else begin
        if (push_main) begin
          push_count <= push_count + LEN_SIZE'(1);
          data_in <= data_nx;
        end
        pop_count <= pop_sum[LEN_SIZE] ? '1 : pop_sum[LEN_SIZE-1:0];
        // quiet completion wins a tie with timeout; a timeout alone is always an error
        if (state == DRAIN && state_n == DONE) error <= !quiet_end || pop_count != push_count;
      end
    end
  end
endmodule

// File: tb/tb_traffic_gen.sv
// tb_traffic_gen: table vectors, corner sequences and randomized runs checked against a cycle-walking reference
module tb_traffic_gen;
  logic clk = 1'b0;
  logic reset, start, fifo_pause_main;
  logic [1:0] mode, fifo_empty_d, pop_d;
  logic [5:0] seed, data_in;
  logic [7:0] burst_len, push_count, pop_count;
  logic push_main, init, busy, done, error;
  int checks = 0, errors = 0;
  traffic_gen dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed), .burst_len(burst_len),
    .fifo_pause_main(fifo_pause_main), .fifo_empty_d(fifo_empty_d), .push_main(push_main),
    .data_in(data_in), .pop_d(pop_d), .init(init), .busy(busy), .done(done), .error(error),
    .push_count(push_count), .pop_count(pop_count)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  typedef struct packed {
    logic [1:0] m;
    logic [5:0] s;
    logic [7:0] len;
    logic [3:0][5:0] w;
    logic err;
  } vec_t;
  vec_t tbl [7];
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic logic [5:0] nextw(input logic [1:0] m, input logic [5:0] w);
    case (m)
      2'd0: return w + 6'd1;
      2'd1: return w - 6'd1;
      2'd2: return w;
      default: return {w[4:0], ^(w & 6'b110000)};
    endcase
  endfunction
  function automatic int sat(input int p, input logic [1:0] pe);
    int t;
    t = p + pe[0] + pe[1];
    return t > 255 ? 255 : t;
  endfunction
  task automatic idle_zero(input string n);
    chk({n, "_push"}, push_main, 0);
    chk({n, "_pop"}, pop_d, 0);
    chk({n, "_init"}, init, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_error"}, error, 0);
    chk({n, "_data"}, data_in, 0);
    chk({n, "_pushcnt"}, push_count, 0);
    chk({n, "_popcnt"}, pop_count, 0);
  endtask
  task automatic run(input logic [1:0] m, input logic [5:0] s, input logic [7:0] len, input int pp, input bit stuck);
    int pushes, pops, q, d, guard, noisy;
    logic [5:0] w;
    logic [1:0] pe;
    logic eerr;
    start = 1; mode = m; seed = s; burst_len = len; fifo_pause_main = 0; fifo_empty_d = 2'b11;
    cyc;
    start = 0; mode = 2'($urandom); seed = 6'($urandom); burst_len = 8'($urandom);
    w = (m == 2'd3 && s == 6'd0) ? 6'd1 : s;
    pushes = 0; pops = 0;
    repeat (2) begin
      fifo_empty_d = 2'($urandom); fifo_pause_main = 1'($urandom); start = 1'($urandom);
      #1;
      chk("init", init, 1);
      chk("init_busy", busy, 1);
      chk("init_push", push_main, 0);
      chk("init_pop", pop_d, 0);
      cyc;
    end
    guard = 0;
    while (pushes < int'(len) && guard < 1000) begin
      fifo_pause_main = $urandom_range(0, 99) < pp;
      fifo_empty_d = 2'($urandom); start = 1'($urandom); pe = ~fifo_empty_d;
      #1;
      chk("push_main", push_main, !fifo_pause_main);
      chk("push_pop", pop_d, pe);
      if (!fifo_pause_main) begin
        chk("data", data_in, w);
        w = nextw(m, w);
        pushes++;
      end
      pops = sat(pops, pe);
      guard++;
      cyc;
    end
    chk("push_budget", guard < 1000, 1);
    fifo_pause_main = 0; q = 0; d = 0; noisy = $urandom_range(0, 8);
    while (q < 4 && d < 255) begin
      fifo_empty_d = stuck ? 2'b10 : (d < noisy ? 2'($urandom) : 2'b11);
      start = 1'($urandom); pe = ~fifo_empty_d;
      #1;
      chk("drain_busy", busy, 1);
      chk("drain_push", push_main, 0);
      chk("drain_pop", pop_d, pe);
      pops = sat(pops, pe);
      d++;
      q = (pe == 2'b00) ? q + 1 : 0;
      cyc;
    end
    start = 0; fifo_empty_d = 2'b11;
    #1;
    eerr = (q == 4) ? (pops != pushes) : 1'b1;
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_error", error, eerr);
    chk("done_pushcnt", push_count, pushes);
    chk("done_popcnt", pop_count, pops);
    chk("done_data", data_in, w);
    if (stuck) chk("timeout_len", d, 255);
  endtask
  task automatic ret_test(input int r, input logic eerr);
    int left;
    start = 1; mode = 0; seed = 0; burst_len = 5; fifo_pause_main = 0; fifo_empty_d = 2'b11;
    cyc;
    start = 0;
    repeat (7) cyc;
    left = r;
    while (left > 0) begin
      fifo_empty_d = left >= 2 ? 2'b00 : 2'b10;
      left -= left >= 2 ? 2 : 1;
      cyc;
    end
    fifo_empty_d = 2'b11;
    repeat (3) cyc;
    chk("ret_not_yet", done, 0);
    cyc;
    chk("ret_done", done, 1);
    chk("ret_error", error, eerr);
    chk("ret_popcnt", pop_count, r);
    chk("ret_pushcnt", push_count, 5);
  endtask
  initial begin
    tbl[0] = '{2'd0, 6'h0f, 8'd4, {6'h12, 6'h11, 6'h10, 6'h0f}, 1'b1};
    tbl[1] = '{2'd1, 6'h00, 8'd3, {6'h00, 6'h3e, 6'h3f, 6'h00}, 1'b1};
    tbl[2] = '{2'd3, 6'h00, 8'd3, {6'h00, 6'h04, 6'h02, 6'h01}, 1'b1};
    tbl[3] = '{2'd2, 6'h2a, 8'd3, {6'h00, 6'h2a, 6'h2a, 6'h2a}, 1'b1};
    tbl[4] = '{2'd0, 6'h3e, 8'd3, {6'h00, 6'h00, 6'h3f, 6'h3e}, 1'b1};
    tbl[5] = '{2'd3, 6'h21, 8'd3, {6'h00, 6'h06, 6'h03, 6'h21}, 1'b1};
    tbl[6] = '{2'd1, 6'h05, 8'd0, {6'h00, 6'h00, 6'h00, 6'h00}, 1'b0};
    reset = 1; start = 0; mode = 0; seed = 0; burst_len = 0; fifo_pause_main = 0; fifo_empty_d = 2'b00;
    cyc;
    cyc;
    idle_zero("reset");
    reset = 0;
    fifo_empty_d = 2'b11;
    cyc;
    for (int i = 0; i < 7; i++) begin
      start = 1; mode = tbl[i].m; seed = tbl[i].s; burst_len = tbl[i].len;
      cyc;
      start = 0; fifo_pause_main = 0; fifo_empty_d = 2'b11;
      cyc;
      cyc;
      for (int k = 0; k < int'(tbl[i].len); k++) begin
        #1;
        chk("tbl_push", push_main, 1);
        chk("tbl_data", data_in, tbl[i].w[k]);
        cyc;
      end
      #1;
      chk("tbl_drain_push", push_main, 0);
      repeat (4) cyc;
      chk("tbl_done", done, 1);
      chk("tbl_error", error, tbl[i].err);
      chk("tbl_pushcnt", push_count, tbl[i].len);
    end
    start = 1; mode = 1; seed = 0; burst_len = 3; fifo_pause_main = 0; fifo_empty_d = 2'b11;
    cyc;
    start = 0;
    cyc;
    cyc;
    #1;
    chk("pause_d0", data_in, 6'h00);
    chk("pause_p0", push_main, 1);
    cyc;
    fifo_pause_main = 1;
    repeat (2) begin
      #1;
      chk("pause_low", push_main, 0);
      chk("pause_hold", data_in, 6'h3f);
      cyc;
    end
    fifo_pause_main = 0;
    #1;
    chk("pause_d1", data_in, 6'h3f);
    cyc;
    #1;
    chk("pause_d2", data_in, 6'h3e);
    cyc;
    chk("pause_cnt", push_count, 3);
    chk("pause_drain", push_main, 0);
    repeat (4) cyc;
    ret_test(5, 1'b0);
    ret_test(4, 1'b1);
    start = 1; mode = 0; seed = 6'h10; burst_len = 8;
    cyc;
    start = 0;
    repeat (4) cyc;
    chk("pre_reset_busy", busy, 1);
    reset = 1; fifo_empty_d = 2'b00; fifo_pause_main = 0;
    cyc;
    reset = 0;
    #1;
    idle_zero("midreset");
    cyc;
    idle_zero("midreset_hold");
    run(2'd0, 6'h10, 8'd5, 0, 1'b0);
    for (int n = 0; n < 40; n++)
      run(2'($urandom), 6'($urandom), 8'($urandom_range(0, 12)), $urandom_range(0, 60), 1'b0);
    run(2'd0, 6'h01, 8'd3, 20, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
